// File: rtl/ngalu_pkg.sv
// Shared types for the sequential nandgame ALU: opcodes, flag layout and FSM states.
package ngalu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'h0,
      OP_OR  = 4'h1,
      OP_XOR = 4'h2,
      OP_NOT = 4'h3,
      OP_ADD = 4'h4,
      OP_INC = 4'h5,
      OP_SUB = 4'h6,
      OP_DEC = 4'h7,
      OP_MUL = 4'h8,
      OP_SHL = 4'h9,
      OP_SHR = 4'hA,
      OP_SAR = 4'hB
   } alu_op_e;

   typedef struct packed {
      logic ovf;
      logic carry;
      logic neg;
      logic zero;
   } alu_flags_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } ngalu_state_e;

   localparam logic [3:0] ALU_OP_RESERVED_LO = 4'hC;

endpackage

// File: rtl/ngalu_seq_if.sv
// Request/response bundle between decode (master) and the ALU (slave).
interface ngalu_seq_if
   import ngalu_pkg::*;
#(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic             zx;
   logic             sw;
   logic [WIDTH-1:0] reg1;
   logic [WIDTH-1:0] reg2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] outval;
   alu_flags_t       flags;
   logic             illegal;

   modport master (
      output in_valid, opcode, zx, sw, reg1, reg2, out_ready,
      input  in_ready, out_valid, outval, flags, illegal
   );

   modport slave (
      input  in_valid, opcode, zx, sw, reg1, reg2, out_ready,
      output in_ready, out_valid, outval, flags, illegal
   );
endinterface

// File: rtl/ngalu_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle (used with NGALU_SEQ_MUL_EN).
// done_o and product_o describe the iteration in progress, so the caller can load on the final edge.
module ngalu_mul #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, accNext;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      count_q, count_d;
   logic               busy_q, busy_d;

   assign accNext   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign done_o    = busy_q && (count_q == CW'(WIDTH - 1));
   assign busy_o    = busy_q;
   assign product_o = accNext;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      busy_d   = busy_q;
      if (start_i) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         count_d  = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         acc_d    = accNext;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         count_d  = count_q + CW'(1);
         busy_d   = !done_o;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         count_q  <= '0;
         busy_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         count_q  <= count_d;
         busy_q   <= busy_d;
      end
   end

endmodule

// File: rtl/ngalu_seq.sv
// Handshaked nandgame ALU with registered result and flags.
// Define NGALU_SEQ_MUL_EN to build the iterative multiplier for opcode 8; otherwise opcode 8 is reserved.
module ngalu_seq
   import ngalu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   ngalu_seq_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] xOp, yOp, aluRes;
   logic [SHW-1:0]   shAmt;
   logic [WIDTH:0]   addB, addSum;
   logic             addCin, addOvf, isArith, isLegal, isMulOp;
   logic             outFree, accept, loadAlu;
   alu_flags_t       aluFlags;

   logic [WIDTH-1:0] outval_q, outval_d;
   alu_flags_t       flags_q, flags_d;
   logic             illegal_q, illegal_d, outValid_q, outValid_d;

   assign yOp    = bus.sw ? bus.reg1 : bus.reg2;
   assign xOp    = bus.zx ? '0 : (bus.sw ? bus.reg2 : bus.reg1);
   assign shAmt  = yOp[SHW-1:0];
   assign addSum = {1'b0, xOp} + addB + {{WIDTH{1'b0}}, addCin};
   assign addOvf = (xOp[WIDTH-1] == addB[WIDTH-1]) && (addSum[WIDTH-1] != xOp[WIDTH-1]);

   always_comb begin
      addB    = '0;
      addCin  = 1'b0;
      isArith = 1'b0;
      isMulOp = 1'b0;
      isLegal = (bus.opcode < ALU_OP_RESERVED_LO);
      aluRes  = '0;
      case (bus.opcode)
         OP_AND: aluRes = xOp & yOp;
         OP_OR:  aluRes = xOp | yOp;
         OP_XOR: aluRes = xOp ^ yOp;
         OP_NOT: aluRes = ~xOp;
         OP_ADD: begin addB = {1'b0, yOp}; isArith = 1'b1; end
         OP_INC: begin addB = (WIDTH+1)'(1); isArith = 1'b1; end
         OP_SUB: begin addB = {1'b0, ~yOp}; addCin = 1'b1; isArith = 1'b1; end
         OP_DEC: begin addB = {1'b0, {WIDTH{1'b1}}}; isArith = 1'b1; end
`ifdef NGALU_SEQ_MUL_EN
         OP_MUL: isMulOp = 1'b1;
`else
         OP_MUL: isLegal = 1'b0;
`endif
         OP_SHL: aluRes = xOp << shAmt;
         OP_SHR: aluRes = xOp >> shAmt;
         OP_SAR: aluRes = $unsigned($signed(xOp) >>> shAmt);
         default: ;
      endcase
      if (isArith) aluRes = addSum[WIDTH-1:0];
   end

   assign aluFlags.ovf   = isArith && addOvf;
   assign aluFlags.carry = isArith && addSum[WIDTH];
   assign aluFlags.neg   = aluRes[WIDTH-1];
   assign aluFlags.zero  = (aluRes == '0);

   assign bus.in_ready = rst_n && outFree;
   assign accept       = bus.in_valid && bus.in_ready;
   assign loadAlu      = accept && !isMulOp;

`ifdef NGALU_SEQ_MUL_EN
   ngalu_state_e       state_q, state_d;
   logic               mulStart, mulBusy, mulDone;
   logic [2*WIDTH-1:0] mulProd;
   alu_flags_t         mulFlags;

   ngalu_mul #(.WIDTH(WIDTH)) uMul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mulStart),
      .a_i       (xOp),
      .b_i       (yOp),
      .busy_o    (mulBusy),
      .done_o    (mulDone),
      .product_o (mulProd)
   );

   assign mulFlags.ovf   = 1'b0;
   assign mulFlags.carry = |mulProd[2*WIDTH-1:WIDTH];
   assign mulFlags.neg   = mulProd[WIDTH-1];
   assign mulFlags.zero  = (mulProd[WIDTH-1:0] == '0);
   assign outFree        = (state_q == ST_IDLE) && (!outValid_q || bus.out_ready);

   // A stray idle multiplier while in MUL falls back to IDLE rather than locking up issue.
   always_comb begin
      state_d  = state_q;
      mulStart = 1'b0;
      case (state_q)
         ST_IDLE: if (accept && isMulOp) begin
            state_d  = ST_MUL;
            mulStart = 1'b1;
         end
         ST_MUL:  if (mulDone || !mulBusy) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end
`else
   assign outFree = !outValid_q || bus.out_ready;
`endif

   always_comb begin
      outval_d   = outval_q;
      flags_d    = flags_q;
      illegal_d  = illegal_q;
      outValid_d = outValid_q;
      if (outValid_q && bus.out_ready) outValid_d = 1'b0;
      if (loadAlu) begin
         outval_d   = aluRes;
         flags_d    = aluFlags;
         illegal_d  = !isLegal;
         outValid_d = 1'b1;
      end
`ifdef NGALU_SEQ_MUL_EN
      if (mulDone) begin
         outval_d   = mulProd[WIDTH-1:0];
         flags_d    = mulFlags;
         illegal_d  = 1'b0;
         outValid_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outval_q   <= '0;
         flags_q    <= '0;
         illegal_q  <= 1'b0;
         outValid_q <= 1'b0;
      end else begin
         outval_q   <= outval_d;
         flags_q    <= flags_d;
         illegal_q  <= illegal_d;
         outValid_q <= outValid_d;
      end
   end

   assign bus.out_valid = outValid_q;
   assign bus.outval    = outval_q;
   assign bus.flags     = flags_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_ngalu_seq.sv
// Self-checking bench for ngalu_seq: directed vectors, random ops against an arithmetic model,
// back-pressure, throughput, multiplier latency and reset during a multiply.
module tb_ngalu_seq;
   localparam int W = 16;

   typedef struct packed {
      logic [3:0]   op;
      logic         zx;
      logic         sw;
      logic [W-1:0] r1;
      logic [W-1:0] r2;
      logic [W-1:0] res;
      logic [3:0]   fl;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;

   ngalu_seq_if #(.WIDTH(W)) bus ();

   ngalu_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic over the operation definitions.
   function automatic void refModel(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                    output logic [W-1:0] r, output logic [3:0] f, output logic ill);
      int sx, sy, sr;
      int unsigned amt;
      longint unsigned p;
      logic c, o, arith;
      sx = int'($signed(x));
      sy = int'($signed(y));
      sr = 0;
      amt = int'(y) % W;
      c = 1'b0; o = 1'b0; ill = 1'b0; arith = 1'b0; r = '0;
      p = 0;
      case (op)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'h2: r = x ^ y;
         4'h3: r = ~x;
         4'h4: begin sr = sx + sy; c = (int'(x) + int'(y)) > 65535; arith = 1'b1; end
         4'h5: begin sr = sx + 1;  c = (x == 16'hFFFF);             arith = 1'b1; end
         4'h6: begin sr = sx - sy; c = (x >= y);                    arith = 1'b1; end
         4'h7: begin sr = sx - 1;  c = (x != 16'h0000);             arith = 1'b1; end
`ifdef NGALU_SEQ_MUL_EN
         4'h8: begin p = 64'(x) * 64'(y); r = p[W-1:0]; c = (p >> W) != 0; end
`else
         4'h8: ill = 1'b1;
`endif
         4'h9: r = x << amt;
         4'hA: r = x >> amt;
         4'hB: r = W'($signed(x) >>> amt);
         default: ill = 1'b1;
      endcase
      if (arith) begin
         r = W'(sr);
         o = (sr > 32767) || (sr < -32768);
      end
      f = {o, c, r[W-1], (r == '0)};
   endfunction

   // Presents one request for exactly one clock edge; caller guarantees in_ready.
   task automatic applyStimulus(input logic [3:0] op, input logic zx, input logic sw,
                                input logic [W-1:0] r1, input logic [W-1:0] r2);
      bus.opcode   = op;
      bus.zx       = zx;
      bus.sw       = sw;
      bus.reg1     = r1;
      bus.reg2     = r2;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      bus.opcode = 4'h0; bus.zx = 1'b0; bus.sw = 1'b0; bus.reg1 = '0; bus.reg2 = '0;
      #2;
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_in_ready got=%b want=0", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.outval !== 16'h0000) begin bad++; $display("[TB] FAIL rst_outval got=%h want=0000", bus.outval); end
      total++; if (bus.flags !== 4'b0000) begin bad++; $display("[TB] FAIL rst_flags got=%b want=0000", bus.flags); end
      total++; if (bus.illegal !== 1'b0) begin bad++; $display("[TB] FAIL rst_illegal got=%b want=0", bus.illegal); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rel_in_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rel_out_valid got=%b want=0", bus.out_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      vec_t vecs[12];
      logic eIll;
      vecs = '{
         {4'h6, 1'b0, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 4'b0010},
         {4'h4, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010},
         {4'h7, 1'b0, 1'b0, 16'h0000, 16'h1234, 16'hFFFF, 4'b0010},
         {4'h5, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101},
         {4'h3, 1'b1, 1'b1, 16'h1234, 16'h5678, 16'hFFFF, 4'b0010},
         {4'hB, 1'b0, 1'b0, 16'h8000, 16'h0013, 16'hF000, 4'b0010},
         {4'hD, 1'b0, 1'b0, 16'hABCD, 16'h1234, 16'h0000, 4'b0001},
         {4'h9, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0001, 4'b0000},
         {4'h6, 1'b0, 1'b0, 16'h0007, 16'h0007, 16'h0000, 4'b0101},
         {4'h6, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100},
         {4'h6, 1'b0, 1'b1, 16'h0007, 16'h0005, 16'hFFFE, 4'b0010},
         {4'hA, 1'b0, 1'b0, 16'h8000, 16'hFFF4, 16'h0800, 4'b0000}
      };
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         eIll = (vecs[i].op >= 4'hC);
         applyStimulus(vecs[i].op, vecs[i].zx, vecs[i].sw, vecs[i].r1, vecs[i].r2);
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL dir%0d_valid got=%b want=1", i, bus.out_valid); end
         total++; if (bus.outval !== vecs[i].res) begin bad++; $display("[TB] FAIL dir%0d_outval got=%h want=%h", i, bus.outval, vecs[i].res); end
         total++; if (bus.flags !== vecs[i].fl) begin bad++; $display("[TB] FAIL dir%0d_flags got=%b want=%b", i, bus.flags, vecs[i].fl); end
         total++; if (bus.illegal !== eIll) begin bad++; $display("[TB] FAIL dir%0d_illegal got=%b want=%b", i, bus.illegal, eIll); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [3:0]   op;
      logic         zx, sw, eIll;
      logic [W-1:0] r1, r2, x, y, eRes;
      logic [3:0]   eFl;
      int           waitCnt;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 15));
         zx = ($urandom_range(0, 3) == 0);
         sw = 1'($urandom);
         r1 = 16'($urandom);
         r2 = 16'($urandom);
         x  = zx ? '0 : (sw ? r2 : r1);
         y  = sw ? r1 : r2;
         refModel(op, x, y, eRes, eFl, eIll);
         waitCnt = 0;
         while (!bus.in_ready && waitCnt < 50) begin @(posedge clk); #1; waitCnt++; end
         if (bus.in_ready !== 1'b1) begin
            total++; bad++; $display("[TB] FAIL rand%0d_ready_timeout got=%b want=1", i, bus.in_ready);
         end
         applyStimulus(op, zx, sw, r1, r2);
         waitCnt = 0;
         while (!bus.out_valid && waitCnt < 50) begin @(posedge clk); #1; waitCnt++; end
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rand%0d_valid op=%h got=%b want=1", i, op, bus.out_valid); end
         total++; if (bus.outval !== eRes) begin bad++; $display("[TB] FAIL rand%0d_outval op=%h x=%h y=%h got=%h want=%h", i, op, x, y, bus.outval, eRes); end
         total++; if (bus.flags !== eFl) begin bad++; $display("[TB] FAIL rand%0d_flags op=%h x=%h y=%h got=%b want=%b", i, op, x, y, bus.flags, eFl); end
         total++; if (bus.illegal !== eIll) begin bad++; $display("[TB] FAIL rand%0d_illegal op=%h got=%b want=%b", i, op, bus.illegal, eIll); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]   op;
      logic [W-1:0] eRes;
      logic [3:0]   eFl;
      logic         eIll;
      bus.out_ready = 1'b1;
      bus.zx = 1'b0;
      bus.sw = 1'b0;
      for (int i = 0; i < 10; i++) begin
         op = 4'($urandom_range(0, 10));
         if (op == 4'h8) op = 4'h9;
         bus.opcode   = op;
         bus.reg1     = 16'($urandom);
         bus.reg2     = 16'($urandom);
         bus.in_valid = 1'b1;
         refModel(op, bus.reg1, bus.reg2, eRes, eFl, eIll);
         @(posedge clk); #1;
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_valid got=%b want=1", i, bus.out_valid); end
         total++; if (bus.outval !== eRes) begin bad++; $display("[TB] FAIL b2b%0d_outval got=%h want=%h", i, bus.outval, eRes); end
         total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b%0d_in_ready got=%b want=1", i, bus.in_ready); end
      end
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      applyStimulus(4'h4, 1'b0, 1'b0, 16'h1111, 16'h2222);
      bus.opcode = 4'h2; bus.reg1 = 16'h00FF; bus.reg2 = 16'h0F0F; bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp%0d_valid got=%b want=1", k, bus.out_valid); end
         total++; if (bus.outval !== 16'h3333) begin bad++; $display("[TB] FAIL bp%0d_hold got=%h want=3333", k, bus.outval); end
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp%0d_in_ready got=%b want=0", k, bus.in_ready); end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_drain_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.outval !== 16'h3333) begin bad++; $display("[TB] FAIL bp_drain_first got=%h want=3333", bus.outval); end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_second_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.outval !== 16'h0FF0) begin bad++; $display("[TB] FAIL bp_second_val got=%h want=0ff0", bus.outval); end
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_dup got=%b want=0", bus.out_valid); end
   endtask

   task automatic test_mul();
      bus.out_ready = 1'b1;
      applyStimulus(4'h8, 1'b0, 1'b0, 16'h0100, 16'h0101);
`ifdef NGALU_SEQ_MUL_EN
      for (int k = 1; k <= W; k++) begin
         total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL mul_busy_c%0d in_ready=%b out_valid=%b want 0/0", k, bus.in_ready, bus.out_valid);
         end
         @(posedge clk); #1;
      end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mul_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mul_ready got=%b want=1", bus.in_ready); end
      total++; if (bus.outval !== 16'h0100) begin bad++; $display("[TB] FAIL mul_outval got=%h want=0100", bus.outval); end
      total++; if (bus.flags !== 4'b0100) begin bad++; $display("[TB] FAIL mul_flags got=%b want=0100", bus.flags); end
      total++; if (bus.illegal !== 1'b0) begin bad++; $display("[TB] FAIL mul_illegal got=%b want=0", bus.illegal); end
`else
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mul_off_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.outval !== 16'h0000) begin bad++; $display("[TB] FAIL mul_off_outval got=%h want=0000", bus.outval); end
      total++; if (bus.flags !== 4'b0001) begin bad++; $display("[TB] FAIL mul_off_flags got=%b want=0001", bus.flags); end
      total++; if (bus.illegal !== 1'b1) begin bad++; $display("[TB] FAIL mul_off_illegal got=%b want=1", bus.illegal); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mul_off_ready got=%b want=1", bus.in_ready); end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_mul();
      logic sawValid;
      bus.out_ready = 1'b1;
      applyStimulus(4'h8, 1'b0, 1'b0, 16'h0003, 16'h0005);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmm_valid got=%b want=0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rmm_ready_in_rst got=%b want=0", bus.in_ready); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rmm_ready_rel got=%b want=1", bus.in_ready); end
      sawValid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (bus.out_valid) sawValid = 1'b1;
      end
      total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL rmm_ghost_result got=%b want=0", sawValid); end
      applyStimulus(4'h4, 1'b0, 1'b0, 16'h0010, 16'h0020);
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rmm_add_valid got=%b want=1", bus.out_valid); end
      total++; if (bus.outval !== 16'h0030) begin bad++; $display("[TB] FAIL rmm_add_val got=%h want=0030", bus.outval); end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_backpressure();
      test_mul();
      test_reset_mid_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ngalu_seq.md
# ngalu_seq

Parametrised, handshaked successor of the nandgame combinational ALU. It accepts the same eight logic/arithmetic operations with the `zx`/`sw` operand controls and adds barrel shifts, status flags and an optional iterative multiplier. Results are registered behind a valid/ready interface. It sits between the decode stage and register writeback in the nandgame core. A stalled writeback back-pressures issue.

## Interface
- `WIDTH`, 16: operand/result width, ≥4, power of two.
- `SHW`, $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `opcode` in 4: operation, see Operation.
- `zx` in 1: force x operand to zero.
- `sw` in 1: swap reg1/reg2 before use.
- `reg1`, `reg2` in WIDTH: operands.
- `out_valid` out 1: result/flags valid.
- `out_ready` in 1: consumer accepts result.
- `outval` out WIDTH: result.
- `flags` out 4: {ovf, carry, neg, zero}.
- `illegal` out 1: accepted opcode was reserved/disabled; qualified by `out_valid`.

## Operation
- Operands: y = sw ? reg1 : reg2; x = zx ? 0 : (sw ? reg2 : reg1). Both are captured at the accept edge.
- op[3]=0, legacy set: 0 AND, 1 OR, 2 XOR, 3 NOT x, 4 x+y, 5 x+1, 6 x−y (x+~y+1), 7 x−1 (x+all-ones).
- op[3]=1:
  - 8 MUL: low WIDTH bits of x*y, unsigned.
  - 9 SHL: x << y[SHW-1:0].
  - A SHR logical.
  - B SAR arithmetic.
  - C–F reserved.
- Arithmetic is computed WIDTH+1 wide.
  - carry = bit WIDTH of the sum. For subtract this means carry=1 ⇔ no borrow; for 6, 5 and 7, carry is the carry-out of the literal adder form above.
  - ovf = signed overflow of that add.
- Logic and shift ops: carry=0, ovf=0.
- MUL: carry = (high WIDTH bits ≠ 0), ovf=0.
- zero = (outval==0); neg = outval[WIDTH-1] for every op.
- Reserved opcodes produce outval=0, flags={0,0,0,1}, illegal=1, with single-cycle latency.
- FSM states:
  - IDLE: single-cycle ops load the output register at the accept edge.
  - MUL: entered on an accepted MUL. Runs WIDTH shift-add iterations, one per cycle. In the last iteration it loads the output register and returns to IDLE.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready). The block accepts a new request in the same cycle the old result drains, so throughput is 1/cycle for single-cycle ops.
- `out_valid` clears on an `out_ready` handshake unless a new result loads that edge.
- The output register and flags hold stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - state=IDLE, out_valid=0, outval=0, flags=0, illegal=0.
  - in_ready=0 while rst_n=0, 1 the first cycle after release.
- Single-cycle ops: accept at edge N → out_valid=1 after edge N, i.e. visible in cycle N+1.
- MUL: accept at edge N → in_ready=0 during cycles N+1..N+WIDTH → out_valid=1 after edge N+WIDTH.
- MUL only starts when the output register is empty or draining, so the result never overwrites an unconsumed result.
- Inputs are ignored while !in_ready and are not required to be stable.
- Reset mid-MUL aborts the operation: no result is produced and the state is as after reset.
- Shift amount uses only the low SHW bits of y. A shift by 0 passes x unchanged.

## Configuration
- `NGALU_SEQ_MUL_EN` defined: opcode 8 uses the iterative multiplier and the MUL state exists.
- Not defined:
  - Opcode 8 is treated as reserved: illegal=1, single cycle.
  - No MUL state or multiplier logic is built.
  - in_ready depends only on output occupancy.

## Structure
- Package `ngalu_pkg`:
  - `alu_op_e` 4-bit enum of the opcodes above.
  - `alu_flags_t` packed struct {ovf, carry, neg, zero}.
  - `ALU_OP_RESERVED_LO` = 4'hC.
- Sub-module `ngalu_mul`: iterative unsigned shift-add multiplier.
  - Ports: start/busy/done, WIDTH-bit operands, 2*WIDTH product.
  - Instantiated only under `NGALU_SEQ_MUL_EN`.
- The top holds operand muxing, the single-cycle datapath, flag generation, the FSM and the output register.

## Test plan
- WIDTH=16, out_ready=1: SUB (op 6) x=0x0005, y=0x0007 → outval=0xFFFE, flags: neg=1, carry=0, ovf=0, zero=0, out_valid 1 cycle after accept.
- ADD x=0x7FFF, y=0x0001 → 0x8000, ovf=1, neg=1, carry=0. DEC x=0x0000 → 0xFFFF, carry=0. INC x=0xFFFF → 0x0000, zero=1, carry=1.
- sw=1, zx=1, op 3 (NOT), reg1=0x1234 → outval=0xFFFF. SAR x=0x8000, y=0x0013 (shift 3) → 0xF000.
- MUL enabled: x=0x0100, y=0x0101 → outval=0x0100, carry=1. in_ready low exactly 16 cycles, result after edge N+16.
- Back-pressure: out_ready=0 with two back-to-back requests → first result held stable, in_ready=0. Raise out_ready → second accepted the same edge the first drains, no loss or duplication.
- Reserved op 0xD, and MUL with macro undefined → outval=0, zero=1, illegal=1. Assert rst_n mid-MUL → out_valid=0, in_ready=1 after release, and the next ADD completes normally.
